// File: rtl/uart_rx_if.sv
// Receive-side link bundle: the serial line in, and the decoded byte and status strobes out.
interface uart_rx_if;
  logic       in_rx;
  logic [7:0] out_data;
  logic       byte_ready;
  logic       frame_err;
  logic       busy;

  modport master (
    input  in_rx,
    output out_data, byte_ready, frame_err, busy
  );

  modport slave (
    output in_rx,
    input  out_data, byte_ready, frame_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, mid-bit sampling, start-glitch rejection,
// one-cycle byte_ready / frame_err strobes and a break state for a held-low line.
module uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic      clk,
  input  logic      reset_n,
  uart_rx_if.master rx_if
);

  localparam int DIV   = CLK_HZ / (BAUD * OVS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OVS_W = $clog2(OVS);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t           state;
  logic             rx_meta, rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [OVS_W-1:0] ovs_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  logic tick, ovs_mid, ovs_last;
  assign tick     = (div_cnt == DIV_W'(DIV - 1));
  assign ovs_mid  = (ovs_cnt == OVS_W'(OVS / 2 - 1));
  assign ovs_last = (ovs_cnt == OVS_W'(OVS - 1));

  // NOTE: the synchronizer resets to 1 (idle line) so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_if.in_rx;
      rx_s    <= rx_meta;
    end
  end

  // NOTE: non-blocking assignments throughout, so a later assignment in the same
  // branch (the counter clears on state entry) cleanly overrides the default update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      div_cnt          <= '0;
      ovs_cnt          <= '0;
      bit_cnt          <= '0;
      shift            <= '0;
      rx_if.out_data   <= '0;
      rx_if.byte_ready <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      rx_if.busy       <= 1'b0;
    end else begin
      rx_if.byte_ready <= 1'b0;
      rx_if.frame_err  <= 1'b0;
      div_cnt          <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) ovs_cnt <= ovs_last ? '0 : ovs_cnt + OVS_W'(1);

      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            rx_if.busy <= 1'b1;
            div_cnt    <= '0;
            ovs_cnt    <= '0;
          end
        end
        START: begin
          // Still low at mid start bit means a real frame, otherwise a glitch.
          if (tick && ovs_mid) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state      <= IDLE;
              rx_if.busy <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick && ovs_last) begin
            shift <= {rx_s, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              div_cnt <= '0;
              ovs_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        STOP: begin
          if (tick && ovs_last) begin
            div_cnt <= '0;
            ovs_cnt <= '0;
            if (rx_s) begin
              rx_if.out_data   <= shift;
              rx_if.byte_ready <= 1'b1;
              state            <= IDLE;
              rx_if.busy       <= 1'b0;
            end else begin
              rx_if.frame_err <= 1'b1;
              state           <= BRK;
            end
          end
        end
        BRK: begin
          if (rx_s) begin
            state      <= IDLE;
            rx_if.busy <= 1'b0;
            div_cnt    <= '0;
            ovs_cnt    <= '0;
          end
        end
        default: begin
          state      <= IDLE;
          rx_if.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clks/bit: expected bytes queued when a frame is sent,
// popped and compared when byte_ready pulses.
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if rx_if ();

  uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVS(16)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rx_if  (rx_if)
  );

  int checks = 0;
  int errors = 0;
  int byte_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_last = 8'h00;
  logic prev_strobe = 1'b0;

  // Scoreboard side: every byte_ready is matched against the oldest queued byte.
  always @(negedge clk) begin
    if (reset_n) begin
      if (rx_if.byte_ready) begin
        byte_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, required no byte_ready", rx_if.out_data);
        end else begin
          exp_last = exp_q.pop_front();
          if (rx_if.out_data !== exp_last) begin
            errors++;
            $display("FAIL byte_data: got %02h, required %02h", rx_if.out_data, exp_last);
          end
        end
      end
      if (rx_if.frame_err) ferr_cnt++;
      if (rx_if.byte_ready || rx_if.frame_err) begin
        checks++;
        if ((rx_if.byte_ready && rx_if.frame_err) || prev_strobe) begin
          errors++;
          $display("FAIL strobe_shape: br=%b fe=%b prev=%b, required single isolated pulse",
                   rx_if.byte_ready, rx_if.frame_err, prev_strobe);
        end
      end
      prev_strobe = rx_if.byte_ready || rx_if.frame_err;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  task automatic set_line(input logic v, input int n);
    rx_if.in_rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int period, input logic stop_bit);
    set_line(1'b0, period);
    for (int i = 0; i < 8; i++) set_line(d[i], period);
    set_line(stop_bit, period);
  endtask

  task automatic wait_bytes(input int target, input string name);
    int n = 0;
    while (byte_cnt < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (byte_cnt != target) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, byte_cnt, target);
    end
  endtask

  task automatic check_ferr(input int required, input string name);
    checks++;
    if (ferr_cnt != required) begin
      errors++;
      $display("FAIL %s_frame_err: got %0d, required %0d", name, ferr_cnt, required);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (rx_if.out_data !== 8'h00 || rx_if.byte_ready !== 1'b0 ||
        rx_if.frame_err !== 1'b0 || rx_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got data=%02h br=%b fe=%b busy=%b, required 00 0 0 0", name,
               rx_if.out_data, rx_if.byte_ready, rx_if.frame_err, rx_if.busy);
    end
  endtask

  task automatic test_reset;
    rx_if.in_rx = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    reset_n = 1'b1;
    set_line(1'b1, 10);
    check_reset_values("post_reset_idle");
  endtask

  task automatic test_single;
    int b0 = byte_cnt;
    int f0 = ferr_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 16, 1'b1);
    set_line(1'b1, 20);
    wait_bytes(b0 + 1, "single");
    check_ferr(f0, "single");
  endtask

  task automatic test_back_to_back;
    int b0 = byte_cnt;
    int f0 = ferr_cnt;
    logic [7:0] seq[3] = '{8'h00, 8'hFF, 8'h55};
    foreach (seq[i]) exp_q.push_back(seq[i]);
    foreach (seq[i]) send_frame(seq[i], 16, 1'b1);
    set_line(1'b1, 20);
    wait_bytes(b0 + 3, "back_to_back");
    check_ferr(f0, "back_to_back");
  endtask

  task automatic test_glitch;
    int b0 = byte_cnt;
    int f0 = ferr_cnt;
    logic saw_busy = 1'b0;
    set_line(1'b0, 5);
    rx_if.in_rx = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (rx_if.busy) saw_busy = 1'b1;
    end
    checks++;
    if (saw_busy !== 1'b1 || rx_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got rose=%b now=%b, required rose=1 now=0", saw_busy, rx_if.busy);
    end
    checks++;
    if (byte_cnt != b0 || rx_if.out_data !== exp_last) begin
      errors++;
      $display("FAIL glitch_output: got bytes=%0d data=%02h, required bytes=%0d data=%02h",
               byte_cnt, rx_if.out_data, b0, exp_last);
    end
    check_ferr(f0, "glitch");
  endtask

  task automatic test_frame_error;
    int b0 = byte_cnt;
    int f0 = ferr_cnt;
    send_frame(8'h3C, 16, 1'b0);
    set_line(1'b0, 40);
    set_line(1'b1, 20);
    check_ferr(f0 + 1, "framing");
    checks++;
    if (byte_cnt != b0 || rx_if.out_data !== 8'h55) begin
      errors++;
      $display("FAIL framing_data: got bytes=%0d data=%02h, required bytes=%0d data=55",
               byte_cnt, rx_if.out_data, b0);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 16, 1'b1);
    set_line(1'b1, 20);
    wait_bytes(b0 + 1, "after_break");
    check_ferr(f0 + 1, "after_break");
  endtask

  task automatic test_reset_mid_frame;
    int b0;
    set_line(1'b0, 16);
    for (int i = 0; i < 5; i++) set_line(i[0], 16);
    checks++;
    if (rx_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_busy: got %b, required 1", rx_if.busy);
    end
    rx_if.in_rx = 1'b1;
    reset_n = 1'b0;
    #1;
    check_reset_values("reset_mid_frame");
    exp_last = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    set_line(1'b1, 20);
    b0 = byte_cnt;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 16, 1'b1);
    set_line(1'b1, 20);
    wait_bytes(b0 + 1, "after_reset");
  endtask

  task automatic test_baud_skew;
    int b0 = byte_cnt;
    int f0 = ferr_cnt;
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 15, 1'b1);
    set_line(1'b1, 40);
    wait_bytes(b0 + 1, "skew_fast");
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 17, 1'b1);
    set_line(1'b1, 40);
    wait_bytes(b0 + 2, "skew_slow");
    check_ferr(f0, "skew");
  endtask

  initial begin
    rx_if.in_rx = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_baud_skew();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
